// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master: asserts chip select, shifts out an instruction
// MSB-first, then shifts in a run-time selectable number of read bits.
// The captured read data is published on the done pulse.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start; cs_n high, sclk low
// S_CS_SETUP | cs_n low and first MOSI bit valid, sclk low for CLK_DIV
// S_SHIFT    | one bit per sclk period (CLK_DIV high, then CLK_DIV low)
// S_CS_HOLD  | sclk low, cs_n still low, mosi 0 for CLK_DIV
// S_CS_GAP   | cs_n high for CLK_DIV while busy stays high
module spi_cmd_master #(
  parameter int CLK_DIV     = 4,
  parameter int INST_W      = 8,
  parameter int MAX_RD_BITS = 32,
  parameter int LEN_W       = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INST_W-1:0]      inst,
  input  logic [LEN_W-1:0]       rd_bits,
  output logic                   busy,
  output logic                   done,
  output logic [MAX_RD_BITS-1:0] rd_data,
  output logic                   spi_sclk,
  output logic                   spi_cs_n,
  output logic                   spi_mosi,
  input  logic                   spi_miso
);

  // A CLK_DIV of 1 still needs a one-bit counter that simply stays at zero.
  localparam int HC_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(INST_W + MAX_RD_BITS + 1);

  localparam logic [HC_W-1:0]  HC_LOAD   = HC_W'(CLK_DIV - 1);
  localparam logic [HC_W-1:0]  HC_ONE    = HC_W'(1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0] INST_BITS = BIT_W'(INST_W);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_RD_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_CS_GAP
  } state_t;

  state_t                 state_q,   state_d;
  logic [HC_W-1:0]        hcnt_q,    hcnt_d;
  logic [BIT_W-1:0]       bit_q,     bit_d;
  logic [INST_W-1:0]      inst_sr_q, inst_sr_d;
  logic [LEN_W-1:0]       len_q,     len_d;
  logic [MAX_RD_BITS-1:0] rd_sr_q,   rd_sr_d;
  logic [MAX_RD_BITS-1:0] rd_data_q, rd_data_d;
  logic                   sclk_q,    sclk_d;
  logic                   cs_n_q,    cs_n_d;
  logic                   mosi_q,    mosi_d;
  logic                   busy_q,    busy_d;
  logic                   done_q,    done_d;

  logic                   hc_zero;
  logic [BIT_W-1:0]       bit_last;
  logic [BIT_W-1:0]       bit_nxt;
  logic [INST_W-1:0]      inst_shl;

  // The instruction register drains to zero, so MOSI naturally reads 0
  // once the instruction bits are exhausted.
  assign hc_zero  = (hcnt_q == '0);
  assign bit_last = INST_BITS + BIT_W'(len_q) - BIT_ONE;
  assign bit_nxt  = bit_q + BIT_ONE;
  assign inst_shl = inst_sr_q << 1;

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hcnt_q    <= '0;
      bit_q     <= '0;
      inst_sr_q <= '0;
      len_q     <= '0;
      rd_sr_q   <= '0;
      rd_data_q <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      bit_q     <= bit_d;
      inst_sr_q <= inst_sr_d;
      len_q     <= len_d;
      rd_sr_q   <= rd_sr_d;
      rd_data_q <= rd_data_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    bit_d     = bit_q;
    inst_sr_d = inst_sr_q;
    len_d     = len_q;
    rd_sr_d   = rd_sr_q;
    rd_data_d = rd_data_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CS_SETUP;
          busy_d    = 1'b1;
          cs_n_d    = 1'b0;
          mosi_d    = inst[INST_W-1];
          inst_sr_d = inst;
          len_d     = (rd_bits > LEN_MAX) ? LEN_MAX : rd_bits;
          hcnt_d    = HC_LOAD;
          bit_d     = '0;
          rd_sr_d   = '0;
        end
      end

      S_CS_SETUP: begin
        if (hc_zero) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b1;
          hcnt_d  = HC_LOAD;
        end else begin
          hcnt_d = hcnt_q - HC_ONE;
        end
      end

      S_SHIFT: begin
        if (!hc_zero) begin
          hcnt_d = hcnt_q - HC_ONE;
        end else begin
          hcnt_d = HC_LOAD;
          if (sclk_q) begin
            // Falling edge: present the next instruction bit (or 0).
            sclk_d    = 1'b0;
            inst_sr_d = inst_shl;
            mosi_d    = inst_shl[INST_W-1];
          end else if (bit_q == bit_last) begin
            state_d = S_CS_HOLD;
            mosi_d  = 1'b0;
          end else begin
            // Rising edge: MISO is captured only for read bits.
            bit_d  = bit_nxt;
            sclk_d = 1'b1;
            if (bit_nxt >= INST_BITS) begin
              rd_sr_d = (rd_sr_q << 1) | MAX_RD_BITS'(spi_miso);
            end
          end
        end
      end

      S_CS_HOLD: begin
        if (hc_zero) begin
          state_d = S_CS_GAP;
          cs_n_d  = 1'b1;
          hcnt_d  = HC_LOAD;
        end else begin
          hcnt_d = hcnt_q - HC_ONE;
        end
      end

      S_CS_GAP: begin
        if (hc_zero) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rd_data_d = rd_sr_q;
        end else begin
          hcnt_d = hcnt_q - HC_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench for spi_cmd_master: one instance at CLK_DIV=2 with a MISO
// slave model, one at CLK_DIV=1 for back-to-back transfers.
module tb_spi_cmd_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A (CLK_DIV=2)
  logic        start_a = 1'b0;
  logic [7:0]  inst_a = 8'h00;
  logic [5:0]  rd_bits_a = 6'd0;
  logic        busy_a, done_a, sclk_a, cs_n_a, mosi_a;
  logic [31:0] rd_data_a;
  logic        miso_a = 1'b0;

  // Instance B (CLK_DIV=1)
  logic        start_b = 1'b0;
  logic [7:0]  inst_b = 8'h00;
  logic [5:0]  rd_bits_b = 6'd0;
  logic        busy_b, done_b, sclk_b, cs_n_b, mosi_b;
  logic [31:0] rd_data_b;
  logic        miso_b = 1'b1;

  spi_cmd_master #(.CLK_DIV(2)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .inst(inst_a), .rd_bits(rd_bits_a),
    .busy(busy_a), .done(done_a), .rd_data(rd_data_a),
    .spi_sclk(sclk_a), .spi_cs_n(cs_n_a), .spi_mosi(mosi_a), .spi_miso(miso_a)
  );

  spi_cmd_master #(.CLK_DIV(1)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .inst(inst_b), .rd_bits(rd_bits_b),
    .busy(busy_b), .done(done_b), .rd_data(rd_data_b),
    .spi_sclk(sclk_b), .spi_cs_n(cs_n_b), .spi_mosi(mosi_b), .spi_miso(miso_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // sclk pulse counter and MOSI log sampled at each sclk rise (A)
  int          rise_cnt_a = 0;
  logic [63:0] mosi_log = 64'd0;
  always @(posedge sclk_a) begin
    rise_cnt_a = rise_cnt_a + 1;
    mosi_log   = {mosi_log[62:0], mosi_a};
  end

  // Mode-0 slave model: read bit k is driven after falling edge 8+k
  int          fall_cnt_a = 0;
  logic [31:0] model_word = 32'd0;
  int          model_len = 0;
  always @(negedge sclk_a or posedge cs_n_a) begin
    if (cs_n_a === 1'b1) begin
      fall_cnt_a = 0;
    end else begin
      fall_cnt_a = fall_cnt_a + 1;
      if (fall_cnt_a >= 8 && (fall_cnt_a - 8) < model_len)
        miso_a = model_word[model_len - 1 - (fall_cnt_a - 8)];
      else
        miso_a = 1'($urandom);
    end
  end

  int done_cnt_a = 0;
  always @(negedge clk) if (done_a === 1'b1) done_cnt_a = done_cnt_a + 1;

  // cs_n high-run length and minimum sclk rise spacing (B)
  int   hi_run = 0;
  int   last_gap = 0;
  int   last_rise = -1;
  int   min_gap = 1000;
  logic sclk_b_prev = 1'b0;
  always @(negedge clk) begin
    if (cs_n_b === 1'b1) hi_run = hi_run + 1;
    else begin
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end
    if (sclk_b === 1'b1 && sclk_b_prev === 1'b0) begin
      if (last_rise >= 0 && (cyc - last_rise) < min_gap) min_gap = cyc - last_rise;
      last_rise = cyc;
    end
    sclk_b_prev = sclk_b;
  end

  task automatic run_a(input string tag, input logic [7:0] i_inst, input logic [5:0] i_bits,
                       input logic [31:0] word, input int len, input int exp_cyc,
                       input int exp_pulses, input logic [31:0] exp_rd,
                       input logic [63:0] exp_mosi, input bit poke);
    int   rise0, done0, cyc0;
    bit   seen;
    logic [63:0] mask;
    model_word = word;
    model_len  = len;
    rise0 = rise_cnt_a;
    done0 = done_cnt_a;
    start_a = 1'b1; inst_a = i_inst; rd_bits_a = i_bits;
    @(negedge clk);
    start_a = 1'b0; inst_a = 8'h00; rd_bits_a = 6'd0;
    cyc0 = cyc;
    check({tag, "_busy_e0"}, busy_a, 1'b1);
    check({tag, "_cs_e0"}, cs_n_a, 1'b0);
    check({tag, "_mosi_e0"}, mosi_a, i_inst[7]);
    seen = 1'b0;
    for (int w = 1; w < 400; w++) begin
      if (poke && w == 20) begin start_a = 1'b1; inst_a = 8'hAB; rd_bits_a = 6'd3; end
      if (poke && w == 22) begin start_a = 1'b0; inst_a = 8'h00; rd_bits_a = 6'd0; end
      @(negedge clk);
      if (done_a === 1'b1) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      check({tag, "_timeout"}, 1'b0, 1'b1);
    end else begin
      mask = (64'd1 << exp_pulses) - 64'd1;
      check({tag, "_cycles"}, cyc - cyc0, exp_cyc);
      check({tag, "_busy_done"}, busy_a, 1'b0);
      check({tag, "_cs_done"}, cs_n_a, 1'b1);
      check({tag, "_rd_data"}, rd_data_a, exp_rd);
      check({tag, "_pulses"}, rise_cnt_a - rise0, exp_pulses);
      check({tag, "_mosi"}, mosi_log & mask, exp_mosi);
      @(negedge clk);
      check({tag, "_done_1cyc"}, done_a, 1'b0);
      check({tag, "_done_cnt"}, done_cnt_a - done0, 1);
    end
  endtask

  initial begin
    int  r0, cyc0;
    bit  seen;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n_a, 1'b1);
    check("rst_sclk", sclk_a, 1'b0);
    check("rst_mosi", mosi_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_rd_data", rd_data_a, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // RDID: N=32, done at 2*(64+3)=134
    run_a("t1_rdid", 8'h9F, 6'd24, 32'h00EF4018, 24, 134, 32, 32'h00EF4018,
          64'h0000_0000_9F00_0000, 1'b0);
    // WREN: N=8, done at 2*(16+3)=38, MISO noise ignored
    run_a("t2_wren", 8'h06, 6'd0, 32'hFFFF_FFFF, 0, 38, 8, 32'd0,
          64'h0000_0000_0000_0006, 1'b0);
    // start with inst=0xAB while busy must be ignored
    run_a("t3_ignore", 8'h9F, 6'd24, 32'h00EF4018, 24, 134, 32, 32'h00EF4018,
          64'h0000_0000_9F00_0000, 1'b1);

    // reset during SHIFT at bit 12
    model_word = 32'h00EF4018; model_len = 24;
    r0 = rise_cnt_a;
    start_a = 1'b1; inst_a = 8'h9F; rd_bits_a = 6'd24;
    @(negedge clk);
    start_a = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rise_cnt_a - r0 >= 13) begin seen = 1'b1; break; end
    end
    check("t4_reach_bit12", seen, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t4_cs_n", cs_n_a, 1'b1);
    check("t4_sclk", sclk_a, 1'b0);
    check("t4_mosi", mosi_a, 1'b0);
    check("t4_busy", busy_a, 1'b0);
    check("t4_done", done_a, 1'b0);
    check("t4_rd_data", rd_data_a, 32'd0);
    @(negedge clk);
    run_a("t4_rerun", 8'h9F, 6'd24, 32'h00EF4018, 24, 134, 32, 32'h00EF4018,
          64'h0000_0000_9F00_0000, 1'b0);

    // clamp 40 -> 32: N=40, done at 2*(80+3)=166
    run_a("t5_clamp", 8'h03, 6'd40, 32'hA5C3_1E69, 32, 166, 40, 32'hA5C3_1E69,
          64'h0000_0003_0000_0000, 1'b0);

    // back-to-back on instance B, CLK_DIV=1, N=12 -> done at 27
    start_b = 1'b1; inst_b = 8'h9F; rd_bits_b = 6'd4;
    @(negedge clk);
    cyc0 = cyc;
    check("t6_cs_first", cs_n_b, 1'b0);
    seen = 1'b0;
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      if (done_b === 1'b1) begin seen = 1'b1; break; end
    end
    check("t6_done1_seen", seen, 1'b1);
    check("t6_cycles1", cyc - cyc0, 27);
    check("t6_busy_done", busy_b, 1'b0);
    check("t6_cs_done", cs_n_b, 1'b1);
    check("t6_rd_data1", rd_data_b, 32'h0000_000F);
    @(negedge clk);
    cyc0 = cyc;
    start_b = 1'b0;
    check("t6_cs_second", cs_n_b, 1'b0);
    check("t6_busy_second", busy_b, 1'b1);
    seen = 1'b0;
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      if (done_b === 1'b1) begin seen = 1'b1; break; end
    end
    check("t6_done2_seen", seen, 1'b1);
    check("t6_cycles2", cyc - cyc0, 27);
    check("t6_cs_gap", last_gap, 2);
    check("t6_sclk_period", min_gap, 2);
    @(negedge clk);
    check("t6_idle_after", busy_b, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
